// File: rtl/rand_lfsr_pkg.sv
// Shared constants, CON field layout and default tap masks for the multi-channel LFSR peripheral.
package rand_lfsr_pkg;

  localparam int unsigned ADR_W    = 8;
  localparam int unsigned DAT_W    = 32;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned CH_STRIDE = 16;
  localparam int unsigned CH_SHIFT = $clog2(CH_STRIDE);
  localparam int unsigned CH_IDX_W = ADR_W - CH_SHIFT;

  localparam logic [CH_SHIFT-1:0] OFS_CON  = 4'h0;
  localparam logic [CH_SHIFT-1:0] OFS_SEED = 4'h1;
  localparam logic [CH_SHIFT-1:0] OFS_TAPS = 4'h2;
  localparam logic [CH_SHIFT-1:0] OFS_DATA = 4'h3;
  localparam logic [CH_SHIFT-1:0] OFS_CNT  = 4'h4;
  localparam logic [CH_SHIFT-1:0] OFS_STAT = 4'h5;
  localparam logic [ADR_W-1:0]    ADR_ID   = 8'hFC;

  localparam int unsigned CON_EN   = 0;
  localparam int unsigned CON_LOAD = 1;
  localparam int unsigned CON_MODE = 2;
  localparam int unsigned CON_STEP = 4;
  localparam int unsigned CON_AUTO = 5;

  typedef enum logic [1:0] {
    MODE_FREE   = 2'd0,
    MODE_READ   = 2'd1,
    MODE_SINGLE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // Stored (persistent) CON fields; load and step are pulses and are not kept.
  typedef struct packed {
    logic  auto_reseed;
    mode_e mode;
    logic  en;
  } con_t;

  // The reserved encoding behaves as free-run.
  function automatic mode_e eff_mode(input mode_e m);
    return (m == MODE_RSVD) ? MODE_FREE : m;
  endfunction

  // Maximal-length XNOR tap masks (bit k-1 set for tap k).
  function automatic logic [31:0] DEF_TAPS(input int unsigned w);
    logic [31:0] t;
    case (w)
      3:  t = 32'h0000_0006;
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_D008;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rand_lfsr_ch.sv
// One LFSR channel: shift register, step counter, lock detection and auto-reseed.
module rand_lfsr_ch
  import rand_lfsr_pkg::*;
#(
  parameter int unsigned LFSR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  con_t              con,
  input  logic              wr_con,
  input  logic              wr_en,
  input  mode_e             wr_mode,
  input  logic              wr_step,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] taps,
  input  logic              rd_data,
  input  logic              rd_stat,
  input  logic              wr_cnt,
  output logic [LFSR_W-1:0] lfsr,
  output logic [CNT_W-1:0]  cnt,
  output logic              lock
);

  logic              fb;
  logic              step;
  logic              fixed;
  logic [LFSR_W-1:0] nxt;

  // Next state, fixed-point detect and step qualification; load suppresses any step.
  always_comb begin
    fb    = ~(^(lfsr & taps));
    nxt   = {lfsr[LFSR_W-2:0], fb};
    fixed = (nxt == lfsr);
    step  = 1'b0;
    if (con.en) begin
      case (eff_mode(con.mode))
        MODE_FREE: step = 1'b1;
        MODE_READ: step = rd_data;
        default:   step = 1'b0;
      endcase
    end
    if (wr_con && wr_step && wr_en && (eff_mode(wr_mode) == MODE_SINGLE)) begin
      step = 1'b1;
    end
    if (load) begin
      step = 1'b0;
    end
  end

  // Channel state: load > step, clear > increment, lock set > STAT-read clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= '0;
      cnt  <= '0;
      lock <= 1'b0;
    end else begin
      if (load) begin
        lfsr <= seed;
      end else if (step) begin
        lfsr <= (fixed && con.auto_reseed) ? seed : nxt;
      end

      if (load || wr_cnt) begin
        cnt <= '0;
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (step && fixed) begin
        lock <= 1'b1;
      end else if (rd_stat) begin
        lock <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rand_lfsr_mc.sv
// Multi-channel LFSR peripheral: ICB decode, per-channel CON/SEED/TAPS and read mux.
module rand_lfsr_mc
  import rand_lfsr_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned LFSR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icb_wr,
  input  logic [7:0]  icb_wadr,
  input  logic [31:0] icb_wdat,
  output logic        icb_wack,
  input  logic        icb_rd,
  input  logic [7:0]  icb_radr,
  output logic [31:0] icb_rdat,
  output logic        icb_rack
);

  con_t              con_q  [NUM_CH];
  logic [LFSR_W-1:0] seed_q [NUM_CH];
  logic [LFSR_W-1:0] taps_q [NUM_CH];
  logic [LFSR_W-1:0] lfsr   [NUM_CH];
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [NUM_CH-1:0] lock;

  logic [NUM_CH-1:0] wr_con, wr_seed, wr_taps, wr_cnt, rd_data, rd_stat;
  logic              unused_wdat;

  assign icb_wack    = icb_wr;
  assign icb_rack    = icb_rd;
  assign unused_wdat = ^icb_wdat;

  // icb_dec: per-channel write/read strobes.
  always_comb begin
    wr_con  = '0;
    wr_seed = '0;
    wr_taps = '0;
    wr_cnt  = '0;
    rd_data = '0;
    rd_stat = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (icb_wr && (icb_wadr[ADR_W-1:CH_SHIFT] == CH_IDX_W'(c))) begin
        wr_con[c]  = (icb_wadr[CH_SHIFT-1:0] == OFS_CON);
        wr_seed[c] = (icb_wadr[CH_SHIFT-1:0] == OFS_SEED);
        wr_taps[c] = (icb_wadr[CH_SHIFT-1:0] == OFS_TAPS);
        wr_cnt[c]  = (icb_wadr[CH_SHIFT-1:0] == OFS_CNT);
      end
      if (icb_rd && (icb_radr[ADR_W-1:CH_SHIFT] == CH_IDX_W'(c))) begin
        rd_data[c] = (icb_radr[CH_SHIFT-1:0] == OFS_DATA);
        rd_stat[c] = (icb_radr[CH_SHIFT-1:0] == OFS_STAT);
      end
    end
  end

  // Configuration registers; only the low LFSR_W bits of SEED/TAPS are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        con_q[c]  <= '0;
        seed_q[c] <= '0;
        taps_q[c] <= LFSR_W'(DEF_TAPS(LFSR_W));
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (wr_con[c]) begin
          con_q[c] <= '{auto_reseed: icb_wdat[CON_AUTO],
                        mode:        mode_e'(icb_wdat[CON_MODE+1:CON_MODE]),
                        en:          icb_wdat[CON_EN]};
        end
        if (wr_seed[c]) seed_q[c] <= icb_wdat[LFSR_W-1:0];
        if (wr_taps[c]) taps_q[c] <= icb_wdat[LFSR_W-1:0];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rand_lfsr_ch #(.LFSR_W(LFSR_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .con     (con_q[c]),
      .wr_con  (wr_con[c]),
      .wr_en   (icb_wdat[CON_EN]),
      .wr_mode (mode_e'(icb_wdat[CON_MODE+1:CON_MODE])),
      .wr_step (icb_wdat[CON_STEP]),
      .load    (wr_con[c] & icb_wdat[CON_LOAD]),
      .seed    (seed_q[c]),
      .taps    (taps_q[c]),
      .rd_data (rd_data[c]),
      .rd_stat (rd_stat[c]),
      .wr_cnt  (wr_cnt[c]),
      .lfsr    (lfsr[c]),
      .cnt     (cnt[c]),
      .lock    (lock[c])
    );
  end

  // Read mux; zero when idle or unmapped.
  always_comb begin
    icb_rdat = '0;
    if (icb_rd) begin
      if (icb_radr == ADR_ID) begin
        icb_rdat = {16'd0, 8'(NUM_CH), 8'(LFSR_W)};
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (icb_radr[ADR_W-1:CH_SHIFT] == CH_IDX_W'(c)) begin
          case (icb_radr[CH_SHIFT-1:0])
            OFS_CON:  icb_rdat = {26'd0, con_q[c].auto_reseed, 1'b0, con_q[c].mode, 1'b0, con_q[c].en};
            OFS_SEED: icb_rdat = DAT_W'(seed_q[c]);
            OFS_TAPS: icb_rdat = DAT_W'(taps_q[c]);
            OFS_DATA: icb_rdat = DAT_W'(lfsr[c]);
            OFS_CNT:  icb_rdat = cnt[c];
            OFS_STAT: icb_rdat = {31'd0, lock[c]};
            default:  icb_rdat = '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rand_lfsr_mc.sv
// Scoreboard bench for rand_lfsr_mc: an 8-bit two-channel instance and a 4-bit single-channel instance.
module tb_rand_lfsr_mc;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        wr   = 1'b0;
  logic        rd   = 1'b0;
  logic        sel4 = 1'b0;
  logic [7:0]  wadr = '0;
  logic [7:0]  radr = '0;
  logic [31:0] wdat = '0;
  logic        wr8, rd8, wr4, rd4, wack8, rack8, wack4, rack4;
  logic [31:0] rdat8, rdat4, rdat;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];

  localparam logic [7:0]  RST_ADR [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                          8'h12, 8'hFC, 8'h06, 8'h20, 8'h15, 8'h13};
  localparam logic [31:0] RST_EXP [12] = '{32'h0, 32'h0, 32'hB8, 32'h0, 32'h0, 32'h0,
                                          32'hB8, 32'h208, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0] FR_EXP  [6]  = '{32'h00, 32'h01, 32'h03, 32'h07, 32'h0F, 32'h1E};
  localparam logic [31:0] SR_EXP  [4]  = '{32'h01, 32'h03, 32'h07, 32'h0F};

  assign wr8  = wr & ~sel4;
  assign rd8  = rd & ~sel4;
  assign wr4  = wr & sel4;
  assign rd4  = rd & sel4;
  assign rdat = sel4 ? rdat4 : rdat8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rand_lfsr_mc #(.NUM_CH(2), .LFSR_W(8)) dut (
    .clk(clk), .rst(rst),
    .icb_wr(wr8), .icb_wadr(wadr), .icb_wdat(wdat), .icb_wack(wack8),
    .icb_rd(rd8), .icb_radr(radr), .icb_rdat(rdat8), .icb_rack(rack8)
  );

  rand_lfsr_mc #(.NUM_CH(1), .LFSR_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .icb_wr(wr4), .icb_wadr(wadr), .icb_wdat(wdat), .icb_wack(wack4),
    .icb_rd(rd4), .icb_radr(radr), .icb_rdat(rdat4), .icb_rack(rack4)
  );

  // Reference XNOR LFSR step for width w.
  function automatic logic [31:0] m_step(input logic [31:0] v, input logic [31:0] t, input int w);
    logic [63:0] msk;
    logic        f;
    msk = (64'd1 << w) - 64'd1;
    f   = ~(^(v & t));
    return 32'(({32'd0, v} << 1 | {63'd0, f}) & msk);
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    wr = 1'b1; wadr = a; wdat = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    rd = 1'b1; radr = a;
    #1 d = rdat;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(RST_EXP[i]);
      bus_read(RST_ADR[i], d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin failures++; $display("FAIL reset_reg[%02h]: got 0x%08h expected 0x%08h", RST_ADR[i], d, e); end
    end
    sel4 = 1'b1;
    exp_q.push_back(32'h0000_000C);
    bus_read(8'h02, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL reset_taps4: got 0x%08h expected 0x%08h", d, e); end
    exp_q.push_back(32'h0000_0104);
    bus_read(8'hFC, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL id4: got 0x%08h expected 0x%08h", d, e); end
    sel4 = 1'b0;
    rd = 1'b0; radr = 8'h02;
    #1;
    checks++;
    if (rdat8 !== 32'h0) begin failures++; $display("FAIL idle_rdat: got 0x%08h expected 0x00000000", rdat8); end
    wr = 1'b1; wadr = 8'h06; wdat = 32'h0;
    #1;
    checks++;
    if (wack8 !== 1'b1) begin failures++; $display("FAIL wack_hi: got %b expected 1", wack8); end
    @(negedge clk);
    wr = 1'b0;
    #1;
    checks++;
    if (wack8 !== 1'b0) begin failures++; $display("FAIL wack_lo: got %b expected 0", wack8); end
    rd = 1'b1; radr = 8'h02;
    #1;
    checks++;
    if (rack8 !== 1'b1) begin failures++; $display("FAIL rack_hi: got %b expected 1", rack8); end
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_free_run();
    logic [31:0] d, c, e;
    bus_write(8'h00, 32'h03);
    rd = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(FR_EXP[k]);
      exp_q.push_back(32'(k));
      radr = 8'h03; #1 d = rdat;
      radr = 8'h04; #1 c = rdat;
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin failures++; $display("FAIL free_run_data[%0d]: got 0x%08h expected 0x%08h", k, d, e); end
      e = exp_q.pop_front();
      checks++;
      if (c !== e) begin failures++; $display("FAIL free_run_cnt[%0d]: got 0x%08h expected 0x%08h", k, c, e); end
      @(negedge clk);
    end
    rd = 1'b0;
    bus_write(8'h00, 32'h00);
  endtask

  task automatic test_step_on_read();
    logic [31:0] d, e;
    bus_write(8'h01, 32'h01);
    bus_write(8'h00, 32'h07);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(SR_EXP[k]);
      bus_read(8'h03, d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin failures++; $display("FAIL step_read[%0d]: got 0x%08h expected 0x%08h", k, d, e); end
    end
    idle(10);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'h1E);
    exp_q.push_back(32'd5);
    bus_read(8'h04, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL step_read_cnt4: got 0x%08h expected 0x%08h", d, e); end
    bus_read(8'h03, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL step_read_gap: got 0x%08h expected 0x%08h", d, e); end
    bus_read(8'h04, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL step_read_cnt5: got 0x%08h expected 0x%08h", d, e); end
  endtask

  task automatic test_lock();
    logic [31:0] d, e;
    bus_write(8'h01, 32'hFF);
    bus_write(8'h00, 32'h0B);
    exp_q.push_back(32'h0);
    bus_read(8'h05, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL lock_pre: got 0x%08h expected 0x%08h", d, e); end
    bus_write(8'h00, 32'h19);
    idle(3);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    bus_read(8'h03, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL lock_data: got 0x%08h expected 0x%08h", d, e); end
    bus_read(8'h04, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL lock_cnt: got 0x%08h expected 0x%08h", d, e); end
    bus_read(8'h05, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL lock_stat_set: got 0x%08h expected 0x%08h", d, e); end
    bus_read(8'h05, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL lock_stat_clr: got 0x%08h expected 0x%08h", d, e); end
  endtask

  task automatic test_auto_reseed();
    logic [31:0] d, e, v;
    bus_write(8'h00, 32'h2B);
    bus_write(8'h00, 32'h39);
    exp_q.push_back(32'hFF);
    bus_read(8'h03, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL reseed_locked: got 0x%08h expected 0x%08h", d, e); end
    bus_write(8'h01, 32'h5A);
    bus_write(8'h00, 32'h39);
    exp_q.push_back(32'h5A);
    bus_read(8'h03, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL reseed_load: got 0x%08h expected 0x%08h", d, e); end
    v = 32'h5A;
    for (int k = 0; k < 2; k++) begin
      bus_write(8'h00, 32'h39);
      v = m_step(v, 32'hB8, 8);
      exp_q.push_back(v);
      bus_read(8'h03, d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin failures++; $display("FAIL reseed_resume[%0d]: got 0x%08h expected 0x%08h", k, d, e); end
    end
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    bus_read(8'h04, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL reseed_cnt: got 0x%08h expected 0x%08h", d, e); end
    bus_read(8'h05, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL reseed_stat_set: got 0x%08h expected 0x%08h", d, e); end
    bus_read(8'h05, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL reseed_stat_clr: got 0x%08h expected 0x%08h", d, e); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    logic [7:0]  adrs [5];
    logic [31:0] d2;
    adrs = '{8'h03, 8'h04, 8'h00, 8'h01, 8'h11};
    bus_write(8'h11, 32'h33);
    bus_write(8'h00, 32'h01);
    idle(5);
    rst = 1'b1;
    #1;
    rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'h0);
      radr = adrs[i];
      #1 d = rdat;
      d2 = exp_q.pop_front();
      checks++;
      if (d !== d2) begin failures++; $display("FAIL mid_rst[%02h]: got 0x%08h expected 0x%08h", adrs[i], d, d2); end
    end
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    exp_q.push_back(32'h0);
    bus_read(8'h03, d);
    d2 = exp_q.pop_front();
    checks++;
    if (d !== d2) begin failures++; $display("FAIL post_rst_data: got 0x%08h expected 0x%08h", d, d2); end
  endtask

  task automatic test_multi_channel();
    logic [31:0] d, e, v, v0;
    int          cyc_a, n;
    logic [7:0]  adrs [6];
    logic [31:0] exps [6];
    bus_write(8'h00, 32'h03);
    cyc_a = cyc;
    bus_write(8'h10, 32'h0B);
    v = 32'h0;
    for (int k = 0; k < 3; k++) begin
      bus_write(8'h10, 32'h19);
      v = m_step(v, 32'hB8, 8);
      idle(2);
    end
    bus_write(8'h10, 32'h09);
    exp_q.push_back(v);
    exp_q.push_back(32'd3);
    bus_read(8'h13, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL ch1_data: got 0x%08h expected 0x%08h", d, e); end
    bus_read(8'h14, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL ch1_cnt: got 0x%08h expected 0x%08h", d, e); end
    bus_write(8'h00, 32'h00);
    n  = cyc - cyc_a;
    v0 = 32'h0;
    for (int k = 0; k < n; k++) v0 = m_step(v0, 32'hB8, 8);
    exp_q.push_back(v0);
    exp_q.push_back(32'(n));
    bus_read(8'h03, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL ch0_data: got 0x%08h expected 0x%08h", d, e); end
    bus_read(8'h04, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL ch0_cnt: got 0x%08h expected 0x%08h", d, e); end
    bus_write(8'h12, 32'h1D);
    bus_write(8'h11, 32'hFFFF_FF5A);
    bus_write(8'h14, 32'h1234);
    adrs = '{8'h02, 8'h12, 8'h11, 8'h01, 8'h14, 8'h10};
    exps = '{32'hB8, 32'h1D, 32'h5A, 32'h0, 32'h0, 32'h09};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exps[i]);
      bus_read(adrs[i], d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin failures++; $display("FAIL iso_reg[%02h]: got 0x%08h expected 0x%08h", adrs[i], d, e); end
    end
  endtask

  task automatic test_lfsr4();
    logic [31:0] d, e, v;
    logic [15:0] seen;
    int          nd;
    sel4 = 1'b1;
    bus_write(8'h02, 32'hC);
    bus_write(8'h00, 32'h03);
    rd = 1'b1; radr = 8'h03;
    v = 32'h0; seen = '0; nd = 0;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(v);
      #1 d = rdat;
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin failures++; $display("FAIL lfsr4_data[%0d]: got 0x%08h expected 0x%08h", k, d, e); end
      if (k > 0) begin
        if (!seen[d[3:0]]) nd++;
        seen[d[3:0]] = 1'b1;
      end
      v = m_step(v, 32'hC, 4);
      @(negedge clk);
    end
    rd = 1'b0;
    checks++;
    if (nd != 15 || seen[15]) begin failures++; $display("FAIL lfsr4_distinct: got %0d values (0xF seen=%b) expected 15 (0xF seen=0)", nd, seen[15]); end
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL lfsr4_wrap: got 0x%08h expected 0x00000000", d); end
    bus_write(8'h00, 32'h00);
    exp_q.push_back(32'h0);
    bus_read(8'h05, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL lfsr4_lock: got 0x%08h expected 0x%08h", d, e); end
    sel4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_step_on_read();
    test_lock();
    test_auto_reseed();
    test_reset_mid_run();
    test_multi_channel();
    test_lfsr4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
